// File: rtl/icosoc_mod_pdm_in.sv
// ============================================================================
// Module     : icosoc_mod_pdm_in
// Description: PDM microphone input with boxcar decimation, sample FIFO and
//              icosoc ctrl bus. Define PDM_IN_STEREO_EN for two channels.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module icosoc_mod_pdm_in #(
  parameter int CLOCK_FREQ_HZ   = 20000000,
  parameter int PDM_DIV         = 8,
  parameter int DECIM_LOG2      = 8,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  output logic        pdm_clk,
  input  logic        pdm_data
);

  localparam int unused_clock_freq = CLOCK_FREQ_HZ;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int DIVW  = $clog2(PDM_DIV);
`ifdef PDM_IN_STEREO_EN
  localparam int W = 16;
`else
  localparam int W = 8;
`endif

  logic                     en, ovf;
  logic [1:0]               sync;
  logic [DIVW-1:0]          div;
  logic [DECIM_LOG2-1:0]    bitcnt;
  logic [DECIM_LOG2:0]      acc_l, acc_l_sum;
  logic                     pend;
  logic [W-1:0]             pend_data;
  logic [W-1:0]             mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wptr, rptr, level;
  logic [31:0]              rdat_next;
  logic req, is_data, is_ctrl, empty, full, pop, flush, en_wr, push_ok;
  logic div_wrap, fall_cap, win_end;
  logic unused_wdat;

  assign unused_wdat = ^ctrl_wdat[31:2];

  function automatic logic [7:0] sat8(input logic [DECIM_LOG2:0] a);
    logic [DECIM_LOG2:0] s;
    s = a >> (DECIM_LOG2 - 8);
    return (s > (DECIM_LOG2+1)'(255)) ? 8'hFF : s[7:0];
  endfunction

  // Bus decode: a request is only taken while no completion is in flight.
  assign req     = (ctrl_rd | (|ctrl_wr)) & ~ctrl_done;
  assign is_data = (ctrl_addr == 16'h0000);
  assign is_ctrl = (ctrl_addr == 16'h0004);
  assign level   = wptr - rptr;
  assign empty   = (level == '0);
  assign full    = (level == (FIFO_DEPTH_LOG2+1)'(DEPTH));
  assign pop     = req & ctrl_rd & is_data & ~empty;
  assign en_wr   = req & (|ctrl_wr) & is_ctrl;
  assign flush   = en_wr & ctrl_wdat[1];
  assign push_ok = pend & ~flush & (~full | pop);

  always_comb begin
    rdat_next = '0;
    if (ctrl_rd && is_data) begin
      if (empty) rdat_next = 32'h8000_0000;
      else       rdat_next = {{(32-W){1'b0}}, mem[rptr[FIFO_DEPTH_LOG2-1:0]]};
    end else if (ctrl_rd && is_ctrl) begin
      rdat_next[FIFO_DEPTH_LOG2:0] = level;
      rdat_next[16] = ovf;
      rdat_next[17] = en;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
      en        <= 1'b0;
      sync      <= '0;
    end else begin
      ctrl_done <= req;
      ctrl_rdat <= req ? rdat_next : '0;
      sync      <= {sync[0], pdm_data};
      if (en_wr) en <= ctrl_wdat[0];
    end
  end

  // Clock generation; captures happen on the cycle pdm_clk is driven.
  assign div_wrap = en && (div == DIVW'(PDM_DIV - 1));
  assign fall_cap = div_wrap & pdm_clk;
  assign win_end  = fall_cap & (&bitcnt);
  assign acc_l_sum = acc_l + {{DECIM_LOG2{1'b0}}, sync[1]};

  always_ff @(posedge clk) begin
    if (!resetn || !en) begin
      div     <= '0;
      pdm_clk <= 1'b0;
    end else if (div_wrap) begin
      div     <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div     <= div + DIVW'(1);
    end
  end

  // Every capture belongs to exactly one window of 2**DECIM_LOG2 bits.
  always_ff @(posedge clk) begin
    if (!resetn || !en) begin
      bitcnt <= '0;
      acc_l  <= '0;
    end else if (fall_cap) begin
      bitcnt <= bitcnt + DECIM_LOG2'(1);
      acc_l  <= win_end ? '0 : acc_l_sum;
    end
  end

`ifdef PDM_IN_STEREO_EN
  logic [DECIM_LOG2:0] acc_r;
  logic                rise_cap;
  assign rise_cap = div_wrap & ~pdm_clk;

  always_ff @(posedge clk) begin
    if (!resetn || !en)  acc_r <= '0;
    else if (win_end)    acc_r <= '0;
    else if (rise_cap)   acc_r <= acc_r + {{DECIM_LOG2{1'b0}}, sync[1]};
  end

  always_ff @(posedge clk) begin
    if (win_end) pend_data <= {sat8(acc_r), sat8(acc_l_sum)};
  end
`else
  always_ff @(posedge clk) begin
    if (win_end) pend_data <= sat8(acc_l_sum);
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) pend <= 1'b0;
    else         pend <= win_end;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[FIFO_DEPTH_LOG2-1:0]] <= pend_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + (FIFO_DEPTH_LOG2+1)'(1);
      if (pop)     rptr <= rptr + (FIFO_DEPTH_LOG2+1)'(1);
      if (pend && full && !pop) ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icosoc_mod_pdm_in.sv
// ============================================================================
// Module     : tb_icosoc_mod_pdm_in
// Description: Randomized self-checking bench with a window-counting model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icosoc_mod_pdm_in;
  localparam int PDM_DIV = 4;
  localparam int DECIM_LOG2 = 8;
  localparam int FDL = 3;
  localparam int DEPTH = 1 << FDL;
  localparam int WIN = 1 << DECIM_LOG2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] ctrl_wr = '0;
  logic ctrl_rd = 1'b0;
  logic [15:0] ctrl_addr = '0;
  logic [31:0] ctrl_wdat = '0;
  logic [31:0] ctrl_rdat;
  logic ctrl_done, pdm_clk;
  logic pdm_data = 1'b0;

  int checks = 0;
  int errors = 0;

  // Microphone model and reference: counts ones per window of falling captures.
  bit model_en = 0, en_shadow = 0;
  int cap_cnt = 0, sum_l = 0, sum_r = 0;
  int lmode = 0, rmode = 0;
  logic alt_l = 1'b1;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  icosoc_mod_pdm_in #(
    .CLOCK_FREQ_HZ(20000000), .PDM_DIV(PDM_DIV),
    .DECIM_LOG2(DECIM_LOG2), .FIFO_DEPTH_LOG2(FDL)
  ) dut (
    .clk(clk), .resetn(resetn), .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd),
    .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat),
    .ctrl_done(ctrl_done), .pdm_clk(pdm_clk), .pdm_data(pdm_data)
  );

  function automatic logic pick(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int sat(input int s);
    int v;
    v = s / (1 << (DECIM_LOG2 - 8));
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge pdm_clk or negedge pdm_clk) begin
    if (pdm_clk) begin
      if (model_en) sum_r += int'(pdm_data);
      if (lmode == 3) begin pdm_data = alt_l; alt_l = ~alt_l; end
      else pdm_data = pick(lmode);
    end else begin
      if (model_en) begin
        sum_l += int'(pdm_data);
        cap_cnt++;
        if (cap_cnt == WIN) begin
`ifdef PDM_IN_STEREO_EN
          exp_q.push_back(32'((sat(sum_r) << 8) | sat(sum_l)));
`else
          exp_q.push_back(32'(sat(sum_l)));
`endif
          cap_cnt = 0; sum_l = 0; sum_r = 0;
        end
      end
      pdm_data = pick(rmode);
    end
  end

  task automatic bus(input logic rd, input logic [3:0] wr, input logic [15:0] addr,
                     input logic [31:0] wdat, output logic [31:0] rdat, output int lat);
    @(posedge clk); #1;
    ctrl_rd = rd; ctrl_wr = wr; ctrl_addr = addr; ctrl_wdat = wdat;
    lat = 0; rdat = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ctrl_done) begin lat = i; rdat = ctrl_rdat; break; end
    end
    ctrl_rd = 1'b0; ctrl_wr = '0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%h: no ctrl_done within 8 cycles, required 1", addr);
    end
  endtask

  task automatic wait_fall();
    int n = 0;
    while (pdm_clk !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    while (pdm_clk !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL pdm_clk_stalled: pdm_clk=%b after %0d cycles, required a falling edge", pdm_clk, n);
    end
  endtask

  task automatic write_ctrl(input logic [31:0] w);
    logic [31:0] d; int lat;
    if (en_shadow) wait_fall();
    if (w[0] && !en_shadow) begin pdm_data = pick(rmode); alt_l = 1'b1; end
    bus(1'b0, 4'hF, 16'h0004, w, d, lat);
    if (w[1]) exp_q.delete();
    if (w[0] && !en_shadow) begin cap_cnt = 0; sum_l = 0; sum_r = 0; end
    model_en = w[0]; en_shadow = w[0];
  endtask

  task automatic wait_level(input int min_level, input int polls);
    logic [31:0] d; int lat; int n = 0;
    forever begin
      bus(1'b1, 4'h0, 16'h0004, 32'h0, d, lat);
      if (int'(d[FDL:0]) >= min_level || n >= polls) break;
      repeat (32) @(posedge clk);
      n++;
    end
    if (n >= polls) begin
      checks++; errors++;
      $display("FAIL level_timeout: level=%0d, required >=%0d", d[FDL:0], min_level);
    end
  endtask

  task automatic read_sample(input string name, output logic [31:0] d);
    logic [31:0] e; int lat;
    wait_level(1, 200);
    bus(1'b1, 4'h0, 16'h0000, 32'h0, d, lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, d, e);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; int lat; bit seen;
    resetn = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (ctrl_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", ctrl_done); end
    checks++; if (ctrl_rdat !== 32'h0) begin errors++; $display("FAIL rst_rdat: got %h, required 0", ctrl_rdat); end
    checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL rst_pdm_clk: got %b, required 0", pdm_clk); end
    resetn = 1'b1;
    bus(1'b1, 4'h0, 16'h0004, 32'h0, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h, required 0", d); end
    checks++; if (lat != 1) begin errors++; $display("FAIL done_latency: got %0d, required 1", lat); end
    @(posedge clk); #1;
    checks++; if (ctrl_done !== 1'b0) begin errors++; $display("FAIL done_width: got %b, required 0", ctrl_done); end
    seen = 0;
    repeat (100) begin @(posedge clk); #1; if (pdm_clk !== 1'b0) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL pdm_clk_idle: got toggling, required 0"); end
    bus(1'b1, 4'h0, 16'h0000, 32'h0, d, lat);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL empty_read: got %h, required 80000000", d); end
    bus(1'b1, 4'h0, 16'h0010, 32'h0, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL other_addr: got %h, required 0", d); end
    bus(1'b0, 4'h1, 16'h0000, 32'hFFFF_FFFF, d, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL data_wr_done: got %0d, required 1", lat); end
    bus(1'b0, 4'h8, 16'h0010, 32'hFFFF_FFFF, d, lat);
    bus(1'b1, 4'h0, 16'h0004, 32'h0, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ignored_writes: got %h, required 0", d); end
  endtask

  task automatic test_constant();
    logic [31:0] d;
    lmode = 1; rmode = 0;
    write_ctrl(32'h1);
    read_sample("ones_model", d);
    checks++; if (d[7:0] !== 8'hFF) begin errors++; $display("FAIL ones_sat: got %h, required ff", d[7:0]); end
    write_ctrl(32'h2);
    lmode = 2;
    write_ctrl(32'h1);
    read_sample("zeros_model", d);
    checks++; if (d[7:0] !== 8'h00) begin errors++; $display("FAIL zeros: got %h, required 00", d[7:0]); end
  endtask

  task automatic test_alternating();
    logic [31:0] d; int t = 0, t1 = -1, t2 = -1; logic prev;
    write_ctrl(32'h2);
    lmode = 3;
    write_ctrl(32'h1);
    prev = pdm_clk;
    while (t2 < 0 && t < 200) begin
      @(posedge clk); #1; t++;
      if (pdm_clk && !prev) begin if (t1 < 0) t1 = t; else t2 = t; end
      prev = pdm_clk;
    end
    checks++;
    if (t2 - t1 != 2 * PDM_DIV) begin errors++; $display("FAIL pdm_period: got %0d, required %0d", t2 - t1, 2 * PDM_DIV); end
    for (int i = 0; i < 2; i++) begin
      read_sample("alt_model", d);
      checks++; if (d[7:0] !== 8'h80) begin errors++; $display("FAIL alt_half: got %h, required 80", d[7:0]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    write_ctrl(32'h2);
    lmode = 0; rmode = 0;
    write_ctrl(32'h1);
    for (int i = 0; i < 3; i++) read_sample("random_model", d);
  endtask

  task automatic test_overflow();
    logic [31:0] d, e; int lat; int n = 0;
    write_ctrl(32'h2);
    lmode = 0;
    write_ctrl(32'h1);
    do begin
      repeat (64) @(posedge clk);
      bus(1'b1, 4'h0, 16'h0004, 32'h0, d, lat);
      n++;
    end while (!d[16] && n < 500);
    checks++;
    if (d !== (32'h0003_0000 | DEPTH)) begin errors++; $display("FAIL ovf_status: got %h, required %h", d, 32'h0003_0000 | DEPTH); end
    bus(1'b1, 4'h0, 16'h0000, 32'h0, d, lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++; if (d !== e) begin errors++; $display("FAIL ovf_oldest: got %h, required %h", d, e); end
    write_ctrl(32'h3);
    bus(1'b1, 4'h0, 16'h0004, 32'h0, d, lat);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL flush_status: got %h, required 00020000", d); end
  endtask

  task automatic test_en_toggle();
    logic [31:0] d; int lat;
    write_ctrl(32'h2);
    bus(1'b1, 4'h0, 16'h0000, 32'h0, d, lat);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL empty_read2: got %h, required 80000000", d); end
    lmode = 2;
    write_ctrl(32'h1);
    repeat (WIN * PDM_DIV) @(posedge clk);
    write_ctrl(32'h0);
    bus(1'b1, 4'h0, 16'h0004, 32'h0, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL disabled_status: got %h, required 0", d); end
    lmode = 1;
    write_ctrl(32'h1);
    read_sample("reenable_model", d);
    checks++; if (d[7:0] !== 8'hFF) begin errors++; $display("FAIL no_partial_merge: got %h, required ff", d[7:0]); end
  endtask

`ifdef PDM_IN_STEREO_EN
  task automatic test_stereo();
    logic [31:0] d;
    write_ctrl(32'h2);
    lmode = 1; rmode = 2;
    write_ctrl(32'h1);
    read_sample("stereo_lr_model", d);
    checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL stereo_left: got %h, required 000000ff", d); end
    write_ctrl(32'h2);
    lmode = 2; rmode = 1;
    write_ctrl(32'h1);
    read_sample("stereo_rl_model", d);
    checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL stereo_right: got %h, required 0000ff00", d); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d; int lat;
    write_ctrl(32'h2);
    lmode = 0;
    write_ctrl(32'h1);
    repeat (WIN * 2 * PDM_DIV + 300) @(posedge clk);
    #1 resetn = 1'b0;
    model_en = 0; en_shadow = 0; exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    checks++; if (pdm_clk !== 1'b0 || ctrl_done !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got pdm_clk=%b done=%b, required 0/0", pdm_clk, ctrl_done); end
    bus(1'b1, 4'h0, 16'h0004, 32'h0, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_status: got %h, required 0", d); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_alternating();
    test_random();
    test_overflow();
    test_en_toggle();
`ifdef PDM_IN_STEREO_EN
    test_stereo();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
